// File: rtl/sigmoid_pkg.sv
// Shared constants for the Q8.24 sigmoid activation: formats, saturation point
// and the nine interpolation knots K[k] = round(sigmoid(k) * 2^24).
package sigmoid_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 24;
    localparam int KNOTS = 9;

    localparam logic [WIDTH-1:0] ONE = 32'h0100_0000;

    // |z| at or above this integer part is indistinguishable from 1.0 here
    localparam logic [WIDTH-FRAC-1:0] SAT_INT = 8'd8;

    localparam logic signed [WIDTH-1:0] MIN_Z = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] knot(input logic [3:0] k);
        logic [WIDTH-1:0] v;
        case (k)
            4'd0:    v = 32'h0080_0000;
            4'd1:    v = 32'h00BB_26A8;
            4'd2:    v = 32'h00E1_7BEB;
            4'd3:    v = 32'h00F3_DBE6;
            4'd4:    v = 32'h00FB_6541;
            4'd5:    v = 32'h00FE_4961;
            4'd6:    v = 32'h00FF_5DF4;
            4'd7:    v = 32'h00FF_C44B;
            default: v = 32'h00FF_EA06;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sigmoid_pipe_mult_2in.sv
// Two-input signed fixed-point multiplier: full product shifted right by FRAC
// and truncated back to WIDTH bits.
module mult_2in #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] full;
    logic                      unused_bits;

    assign full = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign p    = full[FRAC +: WIDTH];

    // Discarded fraction and overflow bits of the full product
    assign unused_bits = ^{full[FRAC-1:0], full[2*WIDTH-1:FRAC+WIDTH]};

endmodule

// File: rtl/sigmoid_pipe.sv
// Three-stage Q8.24 sigmoid: magnitude/segment split, knot lookup and slope
// multiply, then offset add with saturation and odd-symmetry fold.
module sigmoid_pipe
    import sigmoid_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [WIDTH-1:0] i_z,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic signed [WIDTH-1:0] o_a,
    output logic signed [WIDTH-1:0] o_z
);

    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] z);
        logic signed [WIDTH-1:0] neg;
        neg = -z;
        return z[WIDTH-1] ? $unsigned(neg) : $unsigned(z);
    endfunction

    // MIN_Z has no positive twin, so it is forced into saturation directly
    function automatic logic sat_flag(input logic signed [WIDTH-1:0] z,
                                      input logic [WIDTH-1:0]        m);
        return (z == MIN_Z) || (m[WIDTH-1:FRAC] >= SAT_INT);
    endfunction

    // Clamp to ONE when saturated, then mirror around 0.5 for negative z
    function automatic logic [WIDTH-1:0] fold_out(input logic [WIDTH-1:0] y,
                                                  input logic             sat,
                                                  input logic             s);
        logic [WIDTH-1:0] ys;
        ys = sat ? ONE : y;
        return s ? (ONE - ys) : ys;
    endfunction

    logic en;
    logic vld_p0, vld_p1, vld_p2;

    logic [WIDTH-1:0] mag_in;
    logic             sat_in;

    logic                    s_p0, sat_p0;
    logic [2:0]              n_p0;
    logic [FRAC-1:0]         f_p0;
    logic signed [WIDTH-1:0] z_p0;

    logic [WIDTH-1:0]        k_lo, k_hi;
    logic [FRAC-1:0]         d;
    logic signed [WIDTH-1:0] prod;
    logic                    unused_prod;

    logic                    s_p1, sat_p1;
    logic [WIDTH-1:0]        klo_p1;
    logic [FRAC-1:0]         p_p1;
    logic signed [WIDTH-1:0] z_p1;

    logic [WIDTH-1:0]        y;
    logic signed [WIDTH-1:0] a_p2, z_p2;

    assign en      = !vld_p2 || o_ready;
    assign i_ready = en;
    assign o_valid = vld_p2;
    assign o_a     = a_p2;
    assign o_z     = z_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= i_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: sign, magnitude, saturation, segment index and fraction
    always_comb begin
        mag_in = abs_mag(i_z);
        sat_in = sat_flag(i_z, mag_in);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s_p0   <= i_z[WIDTH-1];
            sat_p0 <= sat_in;
            n_p0   <= mag_in[FRAC+2:FRAC];
            f_p0   <= mag_in[FRAC-1:0];
            z_p0   <= i_z;
        end
    end

    // Stage 2: knot lookup and slope * fraction
    always_comb begin
        k_lo = knot({1'b0, n_p0});
        k_hi = knot({1'b0, n_p0} + 4'd1);
        d    = FRAC'(k_hi - k_lo);
    end

    mult_2in #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .a (signed'({{(WIDTH-FRAC){1'b0}}, d})),
        .b (signed'({{(WIDTH-FRAC){1'b0}}, f_p0})),
        .p (prod)
    );

    // Both operands are below 2^24, so the shifted product always fits in FRAC bits
    assign unused_prod = ^prod[WIDTH-1:FRAC];

    always_ff @(posedge clk) begin
        if (en) begin
            s_p1   <= s_p0;
            sat_p1 <= sat_p0;
            klo_p1 <= k_lo;
            p_p1   <= prod[FRAC-1:0];
            z_p1   <= z_p0;
        end
    end

    // Stage 3: interpolated value, saturation and sign fold
    assign y = klo_p1 + {{(WIDTH-FRAC){1'b0}}, p_p1};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_p2 <= '0;
            z_p2 <= '0;
        end else if (en && vld_p1) begin
            a_p2 <= signed'(fold_out(y, sat_p1, s_p1));
            z_p2 <= z_p1;
        end
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Bench for sigmoid_pipe: directed boundary cases, backpressure, random traffic
// against a real-arithmetic reference, and mid-stream reset.
module tb_sigmoid_pipe;

    localparam logic [31:0] ONE = 32'h0100_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic               i_ready;
    logic signed [31:0] i_z;
    logic               o_valid;
    logic               o_ready;
    logic signed [31:0] o_a;
    logic signed [31:0] o_z;

    sigmoid_pipe dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_z     (i_z),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_a     (o_a),
        .o_z     (o_z)
    );

    initial forever #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int          kref [9];
    logic [31:0] sbq [$];
    logic        pushed = 1'b0;
    logic        was_stalled = 1'b0;
    logic        have_prev = 1'b0;
    logic [31:0] held_a, held_z, prev_pop_z, prev_pop_a;
    int          n_pops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference: sigmoid by linear interpolation between real-valued knots
    function automatic logic [31:0] model(input logic [31:0] z);
        longint zi, m, f, y;
        int     n;
        if (z == 32'h8000_0000) return 32'h0;
        zi = longint'($signed(z));
        m  = (zi < 0) ? -zi : zi;
        if (m >= 8 * 64'd16777216) begin
            y = ONE;
        end else begin
            n = int'(m / 16777216);
            f = m % 16777216;
            y = kref[n] + ((longint'(kref[n+1] - kref[n]) * f) / 16777216);
        end
        if (zi < 0) y = ONE - y;
        return 32'(y);
    endfunction

    function automatic logic [31:0] rand_z();
        logic [31:0] b [6];
        b[0] = 32'h0000_0000; b[1] = 32'h0800_0000; b[2] = 32'hF800_0000;
        b[3] = 32'h8000_0000; b[4] = 32'h7FFF_FFFF; b[5] = 32'h07FF_FFFF;
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return b[$urandom_range(0, 5)];
            default: return $urandom_range(0, 20 * ONE) - 10 * ONE;
        endcase
    endfunction

    task automatic cycle(input logic v, input logic [31:0] z, input logic rdy);
        logic [31:0] ez;
        @(negedge clk);
        i_valid = v;
        i_z     = z;
        o_ready = rdy;
        #1;
        pushed = v && i_ready;
        if (o_valid && o_ready) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                ez = sbq.pop_front();
                chk("o_z", o_z, ez);
                chk("o_a", o_a, model(ez));
                if (have_prev && ez == -prev_pop_z && ez != 32'h8000_0000)
                    chk("sym", o_a + prev_pop_a, ONE);
                prev_pop_z = ez;
                prev_pop_a = o_a;
                have_prev  = 1'b1;
                n_pops++;
            end
        end
        if (o_valid && !o_ready) begin
            chk("stall_i_ready", 32'(i_ready), 32'd0);
            if (was_stalled) begin
                chk("hold_a", o_a, held_a);
                chk("hold_z", o_z, held_z);
            end
            held_a      = o_a;
            held_z      = o_z;
            was_stalled = 1'b1;
        end else begin
            was_stalled = 1'b0;
        end
        if (pushed) sbq.push_back(z);
    endtask

    task automatic single(input logic [31:0] z, input logic [31:0] exp_a, input string tag);
        cycle(1'b1, z, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk({tag, "_lat1"}, 32'(o_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        chk({tag, "_lat2"}, 32'(o_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        chk({tag, "_lat3"}, 32'(o_valid), 32'd1);
        chk(tag, o_a, exp_a);
    endtask

    initial begin
        logic [31:0] zs [10];
        logic [31:0] cur;
        logic        neg_next;
        int          idx;
        int          n0;

        for (int k = 0; k < 9; k++)
            kref[k] = $rtoi(16777216.0 / (1.0 + $exp(-real'(k))) + 0.5);

        rst = 1'b1; i_valid = 1'b0; i_z = '0; o_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_a", o_a, 32'h0);
        chk("rst_o_z", o_z, 32'h0);
        chk("rst_i_ready", 32'(i_ready), 32'd1);

        single(32'h0000_0000, 32'h0080_0000, "zero");
        single(32'h0100_0000, 32'(kref[1]), "plus_one");
        single(32'hFF00_0000, ONE - 32'(kref[1]), "minus_one");
        single(32'h0800_0000, ONE, "sat_p8");
        single(32'h7FFF_FFFF, ONE, "sat_max");
        single(32'hF800_0000, 32'h0, "sat_m8");
        single(32'h8000_0000, 32'h0, "min_neg");
        single(32'h0080_0000, 32'(kref[0] + (kref[1] - kref[0]) / 2), "half");
        single(32'h07FF_FFFF, model(32'h07FF_FFFF), "below_sat");

        // Backpressure: downstream refuses in cycles 4..8
        for (int i = 0; i < 10; i++) zs[i] = rand_z();
        n0  = n_pops;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            cycle(idx < 10, zs[(idx < 10) ? idx : 0], !(c >= 4 && c <= 8));
            if (pushed) idx++;
        end
        chk("bp_pushed", 32'(idx), 32'd10);
        chk("bp_pops", 32'(n_pops - n0), 32'd10);
        chk("bp_empty", 32'(sbq.size()), 32'd0);

        // Random traffic, z and -z pushed back to back
        cur      = rand_z();
        neg_next = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0);
            if (pushed) begin
                if (!neg_next) begin
                    cur      = -cur;
                    neg_next = 1'b1;
                end else begin
                    cur      = rand_z();
                    neg_next = 1'b0;
                end
            end
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b1);
        chk("rand_drained", 32'(sbq.size()), 32'd0);

        // Reset with three items in flight
        cycle(1'b1, 32'h0100_0000, 1'b1);
        cycle(1'b1, 32'hFE00_0000, 1'b1);
        cycle(1'b1, 32'h0300_0000, 1'b1);
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_o_a", o_a, 32'h0);
        chk("mid_rst_o_z", o_z, 32'h0);
        chk("mid_rst_i_ready", 32'(i_ready), 32'd1);
        sbq.delete();
        was_stalled = 1'b0;
        have_prev   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            chk("no_stale", 32'(o_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
